regfile: RTL and testbench
==========================

// Module: regfile
// PURPOSE
// Architectural register file with per-register ROB rename tags. Sits directly downstream of the
// ROB commit port: it consumes reg_write/reg_rd/reg_val/commit_rob_pos and retires results into x1..x31.
// It is also upstream of the decoder: it tracks which ROB entry will produce each register, and
// answers rs1/rs2 operand queries with {busy, tag, value}.
// PARAMETERS
// REG_CNT    32  number of architectural registers; x0 is hardwired to zero
// REG_POS_W  5   register index width, log2(REG_CNT)
// DATA_W     32  register value width
// ROB_POS_W  4   ROB tag width; the ROB holds 2**ROB_POS_W entries
// PORTS
// clk             in   1          system clock; all state updates on posedge
// rst             in   1          one clock; reset is asynchronous and active-low
// rdy             in   1          global ready; while low, no state changes
// rollback        in   1          ROB mispredict flush; invalidates all rename tags
// issue           in   1          decoder issues an instruction that writes issue_rd
// issue_rd        in   REG_POS_W  destination register of the issued instruction
// issue_rob_pos   in   ROB_POS_W  ROB entry allocated to the issued instruction
// reg_write       in   1          ROB commit writes a register (one-cycle pulse)
// reg_rd          in   REG_POS_W  committed destination register
// reg_val         in   DATA_W     committed value
// commit_rob_pos  in   ROB_POS_W  ROB entry being committed
// rs1_pos         in   REG_POS_W  source 1 query index (combinational)
// rs1_busy        out  1          1 = value still pending in the ROB
// rs1_rob_pos     out  ROB_POS_W  producer tag; meaningful only when rs1_busy=1
// rs1_val         out  DATA_W     register value; meaningful only when rs1_busy=0
// rs2_pos / rs2_busy / rs2_rob_pos / rs2_val: identical to rs1_*
// BEHAVIOUR
// - State per reg: val[DATA_W], busy, tag[ROB_POS_W]. rst low (async): all cleared to 0.
//   Read outputs are combinational, so after reset they read busy=0, tag=0, val=0.
// - rdy=0: the array holds its state; reads stay valid.
// - Commit, on a posedge with rdy=1:
//   - if reg_write and reg_rd!=0: val[reg_rd] <= reg_val.
//   - busy[reg_rd] clears only if busy=1 and tag==commit_rob_pos, and no same-cycle issue to
//     reg_rd. A stale commit never clears a newer rename.
// - Issue, on a posedge with rdy=1 and rollback=0:
//   - if issue and issue_rd!=0: busy[issue_rd] <= 1; tag[issue_rd] <= issue_rob_pos.
//   - When issue and commit hit the same register in one cycle, the issue wins for busy/tag.
//     The committed value is still written.
// - Rollback, on a posedge with rdy=1:
//   - every busy <= 0; issue is ignored that cycle.
//   - The same-cycle commit write is still performed. JALR asserts reg_write and the rollback
//     together, and its link value must land.
// - x0 writes and renames are ignored; a read of x0 always returns busy=0, val=0.
// - Tag wrap-around: tags are compared by equality only. The ROB guarantees a tag is never
//   live twice.
// - No latency on reads. Writes are visible the next cycle, except as described under
//   CONFIGURATION.
// CONFIGURATION
// REGFILE_BYPASS_EN defined:
//   - A read with rsX_pos==reg_rd!=0 and reg_write=1 returns rsX_val=reg_val in the same cycle.
//   - rsX_busy reads 0 in that cycle if busy and tag==commit_rob_pos.
//   - The decoder then never misses a value retiring in the same cycle.
// REGFILE_BYPASS_EN undefined:
//   - Reads return stored state only. The new value and the busy clear appear one cycle after
//     commit.
//   - The decoder must then find the value through the ROB ready/value query.
// TESTING
// rst low mid-run, then high -> x5 reads busy=0, val=0; x0 reads 0 at all times.
// issue rd=3 tag=7; next cycle commit rd=3 tag=7 val=0x1234 -> x3 busy=1 tag=7, then busy=0 val=0x1234.
// issue rd=3 tag=2, then issue rd=3 tag=5, then commit rd=3 tag=2 val=9 -> val=9, busy=1, tag=5.
// Same cycle: commit rd=4 tag=1 val=0xAA, issue rd=4 tag=6 -> val=0xAA, busy=1, tag=6.
// x1,x2 busy; rollback with commit rd=1 val=0x80 -> all busy=0, x1=0x80; a same-cycle issue is dropped.
// BYPASS_EN: commit rd=8 tag=3 val=0x55 while rs1_pos=8 -> same cycle rs1_busy=0, rs1_val=0x55.
//   Without BYPASS_EN, the old value is returned until the next cycle.
// rdy=0 with issue/commit asserted -> no state change; reg_write on x0 -> x0 stays 0.

Source files
------------

// File: rtl/regfile.sv
// Architectural register file with per-register ROB rename tags.
// Commit port writes retired values into x1..x31; the issue port records which
// ROB entry will produce each register; two combinational query ports return
// {busy, tag, value} to the decoder. x0 is hardwired to zero.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle commit
// onto the query ports.
module regfile #(
  parameter int REG_CNT   = 32,
  parameter int REG_POS_W = 5,
  parameter int DATA_W    = 32,
  parameter int ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 issue,
  input  logic [REG_POS_W-1:0] issue_rd,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  input  logic                 reg_write,
  input  logic [REG_POS_W-1:0] reg_rd,
  input  logic [DATA_W-1:0]    reg_val,
  input  logic [ROB_POS_W-1:0] commit_rob_pos,
  input  logic [REG_POS_W-1:0] rs1_pos,
  output logic                 rs1_busy,
  output logic [ROB_POS_W-1:0] rs1_rob_pos,
  output logic [DATA_W-1:0]    rs1_val,
  input  logic [REG_POS_W-1:0] rs2_pos,
  output logic                 rs2_busy,
  output logic [ROB_POS_W-1:0] rs2_rob_pos,
  output logic [DATA_W-1:0]    rs2_val
);

  localparam int RD_W = 1 + ROB_POS_W + DATA_W;

  logic [DATA_W-1:0]    val_r     [REG_CNT];
  logic [ROB_POS_W-1:0] tag_r     [REG_CNT];
  logic [REG_CNT-1:0]   busy_r;

  logic [DATA_W-1:0]    val_nxt_s [REG_CNT];
  logic [ROB_POS_W-1:0] tag_nxt_s [REG_CNT];
  logic [REG_CNT-1:0]   busy_nxt_s;

  logic                 commit_hit_s;
  logic                 issue_hit_s;

  logic [RD_W-1:0]      rd1_s;
  logic [RD_W-1:0]      rd2_s;

  // Look up one query port: stored state, x0 forced to zero, optional commit forwarding.
  function automatic logic [RD_W-1:0] read_port(input logic [REG_POS_W-1:0] pos);
    logic                 b;
    logic [ROB_POS_W-1:0] t;
    logic [DATA_W-1:0]    v;
    b = busy_r[pos];
    t = tag_r[pos];
    v = val_r[pos];
    if (pos == {REG_POS_W{1'b0}}) begin
      b = 1'b0;
      t = {ROB_POS_W{1'b0}};
      v = {DATA_W{1'b0}};
    end else begin
`ifdef REGFILE_BYPASS_EN
      // A write retiring this cycle is forwarded; rdy gates it because a
      // stalled commit does not land.
      if (rdy && reg_write && (pos == reg_rd)) begin
        v = reg_val;
        if (b && (t == commit_rob_pos)) begin
          b = 1'b0;
        end else begin
          b = b;
        end
      end else begin
        v = v;
      end
`else
      v = v;
`endif
    end
    return {b, t, v};
  endfunction

  // Qualified commit and issue strobes; x0 is never written or renamed.
  always_comb begin
    commit_hit_s = rdy && reg_write && (reg_rd != {REG_POS_W{1'b0}});
    issue_hit_s  = rdy && !rollback && issue && (issue_rd != {REG_POS_W{1'b0}});
  end

  // Next-state: commit writes value and retires a matching rename; rollback
  // flushes every rename; an issue overrides the commit's busy/tag update.
  always_comb begin
    val_nxt_s  = val_r;
    tag_nxt_s  = tag_r;
    busy_nxt_s = busy_r;
    if (commit_hit_s) begin
      val_nxt_s[reg_rd] = reg_val;
      if (busy_r[reg_rd] && (tag_r[reg_rd] == commit_rob_pos)) begin
        busy_nxt_s[reg_rd] = 1'b0;
      end else begin
        busy_nxt_s[reg_rd] = busy_r[reg_rd];
      end
    end else begin
      busy_nxt_s = busy_r;
    end
    if (rdy && rollback) begin
      busy_nxt_s = {REG_CNT{1'b0}};
    end else if (issue_hit_s) begin
      busy_nxt_s[issue_rd] = 1'b1;
      tag_nxt_s[issue_rd]  = issue_rob_pos;
    end else begin
      tag_nxt_s = tag_nxt_s;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        val_r[i] <= {DATA_W{1'b0}};
        tag_r[i] <= {ROB_POS_W{1'b0}};
      end
      busy_r <= {REG_CNT{1'b0}};
    end else begin
      val_r  <= val_nxt_s;
      tag_r  <= tag_nxt_s;
      busy_r <= busy_nxt_s;
    end
  end

  // Combinational operand queries for both source ports.
  always_comb begin
    rd1_s = read_port(rs1_pos);
    rd2_s = read_port(rs2_pos);
    {rs1_busy, rs1_rob_pos, rs1_val} = rd1_s;
    {rs2_busy, rs2_rob_pos, rs2_val} = rd2_s;
  end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile (default build; forwarding
// expectations follow REGFILE_BYPASS_EN when it is defined).
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rollback;
  logic        issue;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_rob_pos;
  logic        reg_write;
  logic [4:0]  reg_rd;
  logic [31:0] reg_val;
  logic [3:0]  commit_rob_pos;
  logic [4:0]  rs1_pos;
  logic        rs1_busy;
  logic [3:0]  rs1_rob_pos;
  logic [31:0] rs1_val;
  logic [4:0]  rs2_pos;
  logic        rs2_busy;
  logic [3:0]  rs2_rob_pos;
  logic [31:0] rs2_val;

  int total_cnt;
  int bad_cnt;

  regfile dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
    .reg_write(reg_write), .reg_rd(reg_rd), .reg_val(reg_val),
    .commit_rob_pos(commit_rob_pos),
    .rs1_pos(rs1_pos), .rs1_busy(rs1_busy), .rs1_rob_pos(rs1_rob_pos), .rs1_val(rs1_val),
    .rs2_pos(rs2_pos), .rs2_busy(rs2_busy), .rs2_rob_pos(rs2_rob_pos), .rs2_val(rs2_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rollback = 1'b0; issue = 1'b0; issue_rd = 5'd0; issue_rob_pos = 4'd0;
    reg_write = 1'b0; reg_rd = 5'd0; reg_val = 32'd0; commit_rob_pos = 4'd0;
  endtask

  // Advance one clock; inputs may change 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] p);
    rs1_pos = p;
    rs2_pos = p;
    #1;
  endtask

  task automatic do_issue(input logic [4:0] r, input logic [3:0] t);
    idle();
    issue = 1'b1; issue_rd = r; issue_rob_pos = t;
    cyc();
    idle();
  endtask

  task automatic do_commit(input logic [4:0] r, input logic [3:0] t, input logic [31:0] v);
    idle();
    reg_write = 1'b1; reg_rd = r; commit_rob_pos = t; reg_val = v;
    cyc();
    idle();
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst = 1'b0; rdy = 1'b1; rs1_pos = 5'd0; rs2_pos = 5'd0;
    idle();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    cyc();

    // Reset state
    rd(5'd5);
    chk("rst_x5_busy", {31'd0, rs1_busy}, 32'd0);
    chk("rst_x5_val", rs1_val, 32'd0);
    chk("rst_x5_tag", {28'd0, rs1_rob_pos}, 32'd0);
    rd(5'd0);
    chk("rst_x0_val", rs1_val, 32'd0);

    // Issue then matching commit
    do_issue(5'd3, 4'd7);
    rd(5'd3);
    chk("iss_x3_busy", {31'd0, rs1_busy}, 32'd1);
    chk("iss_x3_tag", {28'd0, rs1_rob_pos}, 32'd7);
    do_commit(5'd3, 4'd7, 32'h1234);
    rd(5'd3);
    chk("cmt_x3_busy", {31'd0, rs1_busy}, 32'd0);
    chk("cmt_x3_val", rs1_val, 32'h1234);

    // Stale commit does not clear newer rename
    do_issue(5'd3, 4'd2);
    do_issue(5'd3, 4'd5);
    do_commit(5'd3, 4'd2, 32'd9);
    rd(5'd3);
    chk("stale_x3_val", rs1_val, 32'd9);
    chk("stale_x3_busy", {31'd0, rs1_busy}, 32'd1);
    chk("stale_x3_tag", {28'd0, rs1_rob_pos}, 32'd5);

    // Same-cycle commit and issue to one register: issue wins busy/tag
    do_issue(5'd4, 4'd1);
    idle();
    reg_write = 1'b1; reg_rd = 5'd4; commit_rob_pos = 4'd1; reg_val = 32'hAA;
    issue = 1'b1; issue_rd = 5'd4; issue_rob_pos = 4'd6;
    cyc();
    idle();
    rd(5'd4);
    chk("same_x4_val", rs2_val, 32'hAA);
    chk("same_x4_busy", {31'd0, rs2_busy}, 32'd1);
    chk("same_x4_tag", {28'd0, rs2_rob_pos}, 32'd6);

    // Rollback with commit write; same-cycle issue dropped
    do_issue(5'd1, 4'd1);
    do_issue(5'd2, 4'd2);
    idle();
    rollback = 1'b1;
    reg_write = 1'b1; reg_rd = 5'd1; commit_rob_pos = 4'd9; reg_val = 32'h80;
    issue = 1'b1; issue_rd = 5'd6; issue_rob_pos = 4'd3;
    cyc();
    idle();
    rd(5'd1);
    chk("rb_x1_busy", {31'd0, rs1_busy}, 32'd0);
    chk("rb_x1_val", rs1_val, 32'h80);
    rd(5'd2);
    chk("rb_x2_busy", {31'd0, rs1_busy}, 32'd0);
    rd(5'd3);
    chk("rb_x3_busy", {31'd0, rs1_busy}, 32'd0);
    rd(5'd4);
    chk("rb_x4_busy", {31'd0, rs2_busy}, 32'd0);
    rd(5'd6);
    chk("rb_x6_dropped", {31'd0, rs1_busy}, 32'd0);

    // Same-cycle read of a retiring register
    do_issue(5'd8, 4'd3);
    idle();
    reg_write = 1'b1; reg_rd = 5'd8; commit_rob_pos = 4'd3; reg_val = 32'h55;
    rd(5'd8);
`ifdef REGFILE_BYPASS_EN
    chk("byp_x8_busy", {31'd0, rs1_busy}, 32'd0);
    chk("byp_x8_val", rs1_val, 32'h55);
`else
    chk("nobyp_x8_busy", {31'd0, rs1_busy}, 32'd1);
    chk("nobyp_x8_val", rs1_val, 32'd0);
`endif
    cyc();
    idle();
    rd(5'd8);
    chk("after_x8_busy", {31'd0, rs1_busy}, 32'd0);
    chk("after_x8_val", rs1_val, 32'h55);

    // rdy=0 freezes state
    idle();
    rdy = 1'b0;
    issue = 1'b1; issue_rd = 5'd10; issue_rob_pos = 4'd4;
    reg_write = 1'b1; reg_rd = 5'd8; commit_rob_pos = 4'd0; reg_val = 32'h77;
    rd(5'd8);
    chk("stall_x8_val_now", rs1_val, 32'h55);
    cyc();
    idle();
    rdy = 1'b1;
    rd(5'd10);
    chk("stall_x10_busy", {31'd0, rs1_busy}, 32'd0);
    rd(5'd8);
    chk("stall_x8_val", rs1_val, 32'h55);

    // x0 write and rename ignored
    idle();
    reg_write = 1'b1; reg_rd = 5'd0; reg_val = 32'hFF;
    issue = 1'b1; issue_rd = 5'd0; issue_rob_pos = 4'd2;
    rd(5'd0);
    chk("x0_now_val", rs1_val, 32'd0);
    cyc();
    idle();
    rd(5'd0);
    chk("x0_val", rs1_val, 32'd0);
    chk("x0_busy", {31'd0, rs2_busy}, 32'd0);

    // Async reset mid-run
    do_commit(5'd5, 4'd0, 32'h99);
    do_issue(5'd5, 4'd4);
    rd(5'd5);
    chk("pre_rst_x5_val", rs1_val, 32'h99);
    chk("pre_rst_x5_busy", {31'd0, rs1_busy}, 32'd1);
    #1 rst = 1'b0;
    rd(5'd5);
    chk("mid_rst_x5_busy", {31'd0, rs1_busy}, 32'd0);
    chk("mid_rst_x5_val", rs1_val, 32'd0);
    rd(5'd3);
    chk("mid_rst_x3_val", rs1_val, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    rd(5'd5);
    chk("post_rst_x5_val", rs1_val, 32'd0);
    rd(5'd0);
    chk("post_rst_x0_val", rs1_val, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
